// File: rtl/sound_mixer_dsm.sv
// sound_mixer_dsm
//   Two-channel volume/mute mixer for a pair of OPLL sample streams. Its
//   output feeds a first-order delta-sigma modulator that produces a 1-bit
//   DAC bitstream.
//
//   Bus side   : two write-only channel registers at IO_BASE (ch0) and
//                IO_BASE+1 (ch1). Layout: [7] mute, [3:0] volume (8 = unity).
//   Audio side : sample_en captures sound_in0/1. pcm_out/pcm_valid follow
//                three cycles later through a fully pipelined datapath.
//                dsm_out is the delta-sigma bitstream of pcm_out and is
//                updated on every clk.
//
//   Ports
//     clk, reset_n                   clock, async active-low reset
//     bus_ioreq/valid/write/address  write decode (address[7:0] only)
//     bus_wdata                      register write data
//     bus_ready                      always 1
//     sound_in0/1, sample_en         signed input samples and capture strobe
//     pcm_out, pcm_valid             signed mixed sample and update strobe
//     dsm_out                        delta-sigma bitstream
module sound_mixer_dsm #(
  parameter logic [7:0] IO_BASE = 8'h7E
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_ioreq,
  input  logic [15:0] bus_address,
  input  logic        bus_write,
  input  logic        bus_valid,
  output logic        bus_ready,
  input  logic [7:0]  bus_wdata,
  input  logic [15:0] sound_in0,
  input  logic [15:0] sound_in1,
  input  logic        sample_en,
  output logic [15:0] pcm_out,
  output logic        pcm_valid,
  output logic        dsm_out
);

  // Channel registers
  logic [3:0] r_vol0, r_vol1;
  logic       r_mute0, r_mute1;

  // Stage 1: captured samples and settings
  logic [15:0] r_s1_smp0, r_s1_smp1;
  logic [3:0]  r_s1_vol0, r_s1_vol1;
  logic        r_s1_mute0, r_s1_mute1;
  logic        r_s1_vld;

  // Stage 2: scaled products
  logic signed [20:0] r_s2_p0, r_s2_p1;
  logic               r_s2_vld;

  // Stage 3 / output
  logic [15:0] r_pcm;
  logic        r_pcm_vld;

  // Delta-sigma
  logic [15:0] r_acc;
  logic        r_dsm;

  logic               w_wr;
  logic signed [20:0] w_a0, w_a1, w_b0, w_b1, w_p0, w_p1;
  logic signed [21:0] w_sum, w_shr;
  logic [15:0]        w_sat;
  logic [16:0]        w_dsm_sum;
  logic               w_unused_addr;

  assign bus_ready     = 1'b1;
  assign w_unused_addr = ^bus_address[15:8];

  assign w_wr = bus_ioreq & bus_valid & bus_write &
                (bus_address[7:1] == IO_BASE[7:1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vol0  <= 4'd8;
      r_vol1  <= 4'd8;
      r_mute0 <= 1'b0;
      r_mute1 <= 1'b0;
    end else if (w_wr) begin
      if (bus_address[0]) begin
        r_vol1  <= bus_wdata[3:0];
        r_mute1 <= bus_wdata[7];
      end else begin
        r_vol0  <= bus_wdata[3:0];
        r_mute0 <= bus_wdata[7];
      end
    end
  end

  // Stage 1 reads the channel registers as they were before this edge, so a
  // write on the same edge affects only the following sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_smp0  <= '0;
      r_s1_smp1  <= '0;
      r_s1_vol0  <= '0;
      r_s1_vol1  <= '0;
      r_s1_mute0 <= 1'b0;
      r_s1_mute1 <= 1'b0;
      r_s1_vld   <= 1'b0;
    end else begin
      r_s1_vld <= sample_en;
      if (sample_en) begin
        r_s1_smp0  <= sound_in0;
        r_s1_smp1  <= sound_in1;
        r_s1_vol0  <= r_vol0;
        r_s1_vol1  <= r_vol1;
        r_s1_mute0 <= r_mute0;
        r_s1_mute1 <= r_mute1;
      end
    end
  end

  // Signed sample times unsigned volume. Both operands are widened to 21 bits
  // (sign-extend the sample, zero-extend the volume) so the product is exact.
  assign w_a0 = {{5{r_s1_smp0[15]}}, r_s1_smp0};
  assign w_a1 = {{5{r_s1_smp1[15]}}, r_s1_smp1};
  assign w_b0 = {17'd0, r_s1_vol0};
  assign w_b1 = {17'd0, r_s1_vol1};
  assign w_p0 = r_s1_mute0 ? '0 : w_a0 * w_b0;
  assign w_p1 = r_s1_mute1 ? '0 : w_a1 * w_b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_p0  <= '0;
      r_s2_p1  <= '0;
      r_s2_vld <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_p0 <= w_p0;
        r_s2_p1 <= w_p1;
      end
    end
  end

  // Sum, floor-divide by 8, then saturate. The result fits in 16 bits only
  // when bits [21:15] all equal the sign bit.
  assign w_sum = {r_s2_p0[20], r_s2_p0} + {r_s2_p1[20], r_s2_p1};
  assign w_shr = w_sum >>> 3;

  always_comb begin
    w_sat = w_shr[15:0];
    if (w_shr[21:15] != {7{w_shr[21]}})
      w_sat = w_shr[21] ? 16'h8000 : 16'h7FFF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pcm     <= '0;
      r_pcm_vld <= 1'b0;
    end else begin
      r_pcm_vld <= r_s2_vld;
      if (r_s2_vld)
        r_pcm <= w_sat;
    end
  end

  // First-order delta-sigma on the offset-binary value of pcm_out.
  // The carry out of the accumulator is the output bit.
  assign w_dsm_sum = {1'b0, r_acc} + {1'b0, r_pcm ^ 16'h8000};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_dsm <= 1'b0;
    end else begin
      r_acc <= w_dsm_sum[15:0];
      r_dsm <= w_dsm_sum[16];
    end
  end

  assign pcm_out   = r_pcm;
  assign pcm_valid = r_pcm_vld;
  assign dsm_out   = r_dsm;

endmodule

// File: tb/tb_sound_mixer_dsm.sv
// Directed testbench for sound_mixer_dsm. Every task starts just after a
// falling edge, drives its inputs immediately, and samples outputs on later
// falling edges.
module tb_sound_mixer_dsm;

  localparam logic [7:0] IO_BASE = 8'h7E;

  logic        clk;
  logic        reset_n;
  logic        bus_ioreq;
  logic [15:0] bus_address;
  logic        bus_write;
  logic        bus_valid;
  logic        bus_ready;
  logic [7:0]  bus_wdata;
  logic [15:0] sound_in0;
  logic [15:0] sound_in1;
  logic        sample_en;
  logic [15:0] pcm_out;
  logic        pcm_valid;
  logic        dsm_out;

  int n_checks;
  int n_pass;

  sound_mixer_dsm #(.IO_BASE(IO_BASE)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus_ioreq   (bus_ioreq),
    .bus_address (bus_address),
    .bus_write   (bus_write),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_wdata   (bus_wdata),
    .sound_in0   (sound_in0),
    .sound_in1   (sound_in1),
    .sample_en   (sample_en),
    .pcm_out     (pcm_out),
    .pcm_valid   (pcm_valid),
    .dsm_out     (dsm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic int pcm_s();
    return int'($signed(pcm_out));
  endfunction

  task automatic bus_wr(input logic [15:0] addr, input logic [7:0] data);
    bus_ioreq   = 1'b1;
    bus_valid   = 1'b1;
    bus_write   = 1'b1;
    bus_address = addr;
    bus_wdata   = data;
    @(negedge clk);
    bus_ioreq = 1'b0;
    bus_valid = 1'b0;
    bus_write = 1'b0;
  endtask

  // One isolated sample: checks exact latency, one-cycle strobe and hold.
  task automatic do_sample(input string tag, input int in0, input int in1, input int exp);
    sound_in0 = 16'(in0);
    sound_in1 = 16'(in1);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    bus_ioreq = 1'b0;
    bus_valid = 1'b0;
    bus_write = 1'b0;
    check({tag, "_vld_c1"}, int'(pcm_valid), 0);
    @(negedge clk);
    check({tag, "_vld_c2"}, int'(pcm_valid), 0);
    @(negedge clk);
    check({tag, "_vld_c3"}, int'(pcm_valid), 1);
    check({tag, "_pcm"}, pcm_s(), exp);
    @(negedge clk);
    check({tag, "_vld_c4"}, int'(pcm_valid), 0);
    check({tag, "_hold"}, pcm_s(), exp);
  endtask

  int burst_in [4] = '{8, 16, 24, -1};

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    reset_n     = 1'b0;
    bus_ioreq   = 1'b0;
    bus_address = '0;
    bus_write   = 1'b0;
    bus_valid   = 1'b0;
    bus_wdata   = '0;
    sound_in0   = '0;
    sound_in1   = '0;
    sample_en   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_pcm", pcm_s(), 0);
    check("rst_vld", int'(pcm_valid), 0);
    check("rst_dsm", int'(dsm_out), 0);
    check("rst_ready", int'(bus_ready), 1);

    // Idle after release: 50% density starting with 0
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("idle_dsm%0d", i), int'(dsm_out), i % 2);
      check($sformatf("idle_vld%0d", i), int'(pcm_valid), 0);
    end
    check("idle_pcm", pcm_s(), 0);

    // Default volumes: (1000*8 - 200*8) >> 3 = 800
    do_sample("dflt", 1000, -200, 800);

    // Full volume saturation: 30000*15*2 >> 3 = 112500 -> clipped
    bus_wr({8'h00, IO_BASE}, 8'h0F);
    bus_wr({8'h00, IO_BASE} + 16'd1, 8'h0F);
    do_sample("sat_pos", 30000, 30000, 32767);
    do_sample("sat_neg", -30000, -30000, -32768);

    // Floor shift: vol 1, (-1) >> 3 = -1 and (-9 + 0) >> 3 = -2
    bus_wr({8'h00, IO_BASE}, 8'h01);
    bus_wr({8'h00, IO_BASE} + 16'd1, 8'h01);
    do_sample("floor_m1", -1, 0, -1);
    do_sample("floor_m9", -9, 0, -2);
    do_sample("floor_p15", 15, 0, 1);

    // Mute ch0 (bits[6:4] ignored), ch1 back to unity
    bus_wr({8'h00, IO_BASE}, 8'h88);
    bus_wr({8'h00, IO_BASE} + 16'd1, 8'h78);
    do_sample("mute", 1000, 16, 16);

    // Non-matching address must not change ch1; upper address bits ignored
    bus_wr({8'h00, IO_BASE} + 16'd2, 8'h00);
    bus_wr({8'h00, IO_BASE} - 16'd1, 8'h00);
    do_sample("nomatch", 1000, 16, 16);

    // Write on the sample_en edge applies only to the next sample
    bus_ioreq   = 1'b1;
    bus_valid   = 1'b1;
    bus_write   = 1'b1;
    bus_address = {8'h12, IO_BASE} + 16'd1;
    bus_wdata   = 8'h04;
    do_sample("same_edge", 1000, 16, 16);
    do_sample("next_vol4", 1000, 16, 8);

    // Back-to-back samples: ch0 unity, ch1 input 0
    bus_wr({8'h00, IO_BASE}, 8'h08);
    sound_in1 = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        sound_in0 = 16'(burst_in[i]);
        sample_en = 1'b1;
      end else begin
        sample_en = 1'b0;
      end
      @(negedge clk);
      if (i >= 2 && i < 6) begin
        check($sformatf("burst_vld%0d", i - 2), int'(pcm_valid), 1);
        check($sformatf("burst_pcm%0d", i - 2), pcm_s(), burst_in[i - 2]);
      end else begin
        check($sformatf("burst_idle%0d", i), int'(pcm_valid), 0);
      end
    end

    // Reset between sample_en and pcm_valid discards the sample
    sound_in0 = 16'd500;
    sound_in1 = 16'd500;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("midrst_pcm", pcm_s(), 0);
    check("midrst_vld", int'(pcm_valid), 0);
    check("midrst_dsm", int'(dsm_out), 0);
    check("midrst_ready", int'(bus_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("midrst_novld%0d", i), int'(pcm_valid), 0);
      check($sformatf("midrst_dsm%0d", i), int'(dsm_out), i % 2);
    end

    // Volumes are back to unity after reset: (100*8 + 100*8) >> 3 = 200
    do_sample("post_rst", 100, 100, 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sound_mixer_dsm.md
SOUND_MIXER_DSM -- requirements
Module: sound_mixer_dsm

Interface
REQ-001 SHALL have parameter IO_BASE, default 8'h7E, giving the even I/O port pair of the mixer registers (IO_BASE+0 = ch0, IO_BASE+1 = ch1).
REQ-002 SHALL have port clk  input  1  system clock; all logic is in this single clock domain.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port bus_ioreq  input  1  I/O cycle qualifier.
REQ-005 SHALL have port bus_address  input  16  bus address; only [7:0] is decoded.
REQ-006 SHALL have port bus_write  input  1  write qualifier.
REQ-007 SHALL have port bus_valid  input  1  bus request valid.
REQ-008 SHALL have port bus_ready  output  1  bus acknowledge; constant 1.
REQ-009 SHALL have port bus_wdata  input  8  write data.
REQ-010 SHALL have port sound_in0  input  16  signed sample, OPLL #0 output.
REQ-011 SHALL have port sound_in1  input  16  signed sample, OPLL #1 output.
REQ-012 SHALL have port sample_en  input  1  one-cycle strobe marking sound_in0/1 valid for capture.
REQ-013 SHALL have port pcm_out  output  16  signed mixed sample.
REQ-014 SHALL have port pcm_valid  output  1  one-cycle strobe, pcm_out updated.
REQ-015 SHALL have port dsm_out  output  1  first-order delta-sigma bitstream of pcm_out.

Function
REQ-016 Register write SHALL occur on the clk edge where bus_ioreq & bus_valid & bus_write & (bus_address[7:1] == IO_BASE[7:1]); bus_address[0] selects the channel.
REQ-017 Each channel register SHALL hold vol[3:0] = bus_wdata[3:0] and mute = bus_wdata[7]; bits [6:4] are ignored; registers are write-only.
REQ-018 Stage 1 SHALL, on an edge with sample_en = 1, capture sound_in0, sound_in1 and both channel registers as held before that edge; a write on the same edge applies to the next sample.
REQ-019 Stage 2 SHALL compute p_n = sample_n * vol_n (signed 16 x unsigned 4 -> signed 21), forced to 0 when mute_n = 1.
REQ-020 Stage 3 SHALL compute s = (p0 + p1) as signed 22 bits, arithmetic shift right by 3 (floor), saturated to [-32768, 32767], registered into pcm_out; vol = 8 is unity gain.
REQ-021 pcm_valid SHALL be 1 exactly 3 clk cycles after the sample_en edge, for one cycle; pcm_out SHALL hold its value between strobes.
REQ-022 The pipeline SHALL be fully pipelined: sample_en on consecutive cycles SHALL yield pcm_valid on consecutive cycles, with no drops.
REQ-023 The delta-sigma stage SHALL run every clk: {c, acc[15:0]} = acc + (pcm_out ^ 16'h8000) (offset binary); dsm_out is registered c.
REQ-024 bus_ready SHALL be 1 at all times, including during reset; writes complete in one cycle.

Reset
REQ-025 While reset_n = 0, the block SHALL force pcm_out = 0, pcm_valid = 0, dsm_out = 0, acc = 0, all pipeline registers = 0, vol0 = vol1 = 8, and mute0 = mute1 = 0.
REQ-026 Reset asserted mid-pipeline SHALL discard in-flight samples; no pcm_valid is produced for them after release.
REQ-027 After reset release, the first sample_en SHALL be processed normally; dsm_out starts from acc = 0.

Verification
REQ-028 Release reset, sample_en idle -> pcm_out = 0, pcm_valid = 0, dsm_out = 0,1,0,1,... (50% density) from the first cycle after release.
REQ-029 Default volumes, sound_in0 = 1000, sound_in1 = -200, one sample_en -> 3 cycles later pcm_valid = 1, pcm_out = 800; pcm_valid = 0 on the following cycle.
REQ-030 Write 0x0F to IO_BASE+0 and IO_BASE+1, inputs 30000/30000 -> pcm_out = 32767; inputs -30000/-30000 -> pcm_out = -32768.
REQ-031 Write 0x88 to IO_BASE+0, sound_in0 = 1000, sound_in1 = 16 -> pcm_out = 16; a write of 0x04 to IO_BASE+1 on the same edge as sample_en -> that sample still uses vol1 = 8, and the next sample uses 4.
REQ-032 sample_en on 4 consecutive cycles with inputs 8, 16, 24, -1 (ch1 = 0) -> 4 consecutive pcm_valid, pcm_out = 8, 16, 24, -1; assert reset_n for 1 cycle between a sample_en and its pcm_valid -> outputs are 0 immediately and no pcm_valid follows.
